// File: rtl/pipelined_prefix_adder.sv
// Fully pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Pipeline: operand stage, LEVELS prefix stages, result stage (LEVELS+2 cycles).
module pipelined_prefix_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  // Index 0 is the operand stage, index k holds the result of prefix level k.
  logic [WIDTH-1:0] g_q  [0:LEVELS];
  logic [WIDTH-1:0] g_d  [0:LEVELS];
  logic [WIDTH-1:0] p_q  [0:LEVELS];
  logic [WIDTH-1:0] p_d  [0:LEVELS];
  logic [WIDTH-1:0] pr_q [0:LEVELS];
  logic [WIDTH-1:0] pr_d [0:LEVELS];
  logic [LEVELS:0]  vld_q, vld_d;
  logic [LEVELS:0]  cin_q, cin_d;
  logic [LEVELS:0]  amsb_q, amsb_d;
  logic [LEVELS:0]  bmsb_q, bmsb_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] carry;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;

  logic             stall;

  // Whole pipe freezes while a result waits for the consumer.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Next-state for operand, prefix and result stages.
  always_comb begin
    g_d         = g_q;
    p_d         = p_q;
    pr_d        = pr_q;
    vld_d       = vld_q;
    cin_d       = cin_q;
    amsb_d      = amsb_q;
    bmsb_d      = bmsb_q;
    g_in        = '0;
    b_eff       = in_sub ? ~in_b : in_b;

    // Operand stage: bitwise generate/propagate; subtract is A + ~B + 1.
    vld_d[0]    = in_valid & in_ready;
    g_d[0]      = in_a & b_eff;
    p_d[0]      = in_a ^ b_eff;
    pr_d[0]     = in_a ^ b_eff;
    cin_d[0]    = in_sub | in_c;
    amsb_d[0]   = in_a[WIDTH-1];
    bmsb_d[0]   = b_eff[WIDTH-1];

    // Prefix levels; carry-in is absorbed into bit 0's generate at level 1.
    for (int k = 1; k <= int'(LEVELS); k++) begin
      g_in = g_q[k-1];
      if (k == 1) begin
        g_in[0] = g_q[0][0] | (p_q[0][0] & cin_q[0]);
      end
      g_d[k]    = g_in | (p_q[k-1] & (g_in << (1 << (k - 1))));
      p_d[k]    = p_q[k-1] & (p_q[k-1] << (1 << (k - 1)));
      pr_d[k]   = pr_q[k-1];
      vld_d[k]  = vld_q[k-1];
      cin_d[k]  = cin_q[k-1];
      amsb_d[k] = amsb_q[k-1];
      bmsb_d[k] = bmsb_q[k-1];
    end

    // Result stage: carry into bit i is the group generate of bits below it.
    carry       = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
    out_sum_d   = pr_q[LEVELS] ^ carry;
    out_cout_d  = g_q[LEVELS][WIDTH-1];
    out_ovf_d   = (amsb_q[LEVELS] == bmsb_q[LEVELS]) &
                  (out_sum_d[WIDTH-1] != amsb_q[LEVELS]);
    out_zero_d  = (out_sum_d == '0);
    out_valid_d = vld_q[LEVELS];
  end

  // Stage registers; every stage advances together unless stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= int'(LEVELS); k++) begin
        g_q[k]  <= '0;
        p_q[k]  <= '0;
        pr_q[k] <= '0;
      end
      vld_q       <= '0;
      cin_q       <= '0;
      amsb_q      <= '0;
      bmsb_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k <= int'(LEVELS); k++) begin
        g_q[k]  <= g_d[k];
        p_q[k]  <= p_d[k];
        pr_q[k] <= pr_d[k];
      end
      vld_q       <= vld_d;
      cin_q       <= cin_d;
      amsb_q      <= amsb_d;
      bmsb_q      <= bmsb_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and streaming checks for pipelined_prefix_adder at widths 4/16/32/64.
module tb_pipelined_prefix_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_c = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf, out_zero;

  logic        sw_valid = 1'b0;
  logic        sw_ready = 1'b1;
  logic [63:0] sw_a = '0;
  logic [63:0] sw_b = '0;
  logic        sw_c = 1'b0;
  logic        sw_sub = 1'b0;
  logic        w4_rdy, w4_valid, w4_cout, w4_ovf, w4_zero;
  logic [3:0]  w4_sum;
  logic        w16_rdy, w16_valid, w16_cout, w16_ovf, w16_zero;
  logic [15:0] w16_sum;
  logic        w64_rdy, w64_valid, w64_cout, w64_ovf, w64_zero;
  logic [63:0] w64_sum;

  always #5 clock = ~clock;

  pipelined_prefix_adder #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero));

  pipelined_prefix_adder #(.WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(w4_rdy),
    .in_a(sw_a[3:0]), .in_b(sw_b[3:0]), .in_c(sw_c), .in_sub(sw_sub),
    .out_valid(w4_valid), .out_ready(sw_ready), .out_sum(w4_sum),
    .out_cout(w4_cout), .out_ovf(w4_ovf), .out_zero(w4_zero));

  pipelined_prefix_adder #(.WIDTH(16)) dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(w16_rdy),
    .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_c(sw_c), .in_sub(sw_sub),
    .out_valid(w16_valid), .out_ready(sw_ready), .out_sum(w16_sum),
    .out_cout(w16_cout), .out_ovf(w16_ovf), .out_zero(w16_zero));

  pipelined_prefix_adder #(.WIDTH(64)) dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(w64_rdy),
    .in_a(sw_a), .in_b(sw_b), .in_c(sw_c), .in_sub(sw_sub),
    .out_valid(w64_valid), .out_ready(sw_ready), .out_sum(w64_sum),
    .out_cout(w64_cout), .out_ovf(w64_ovf), .out_zero(w64_zero));

  // Behavioural reference: plain integer add, returns {cout, ovf, zero, sum}.
  function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic sub);
    logic [63:0] mask, am, bm, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + 65'(sub | c);
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {co, ov, (s == 64'd0), s};
  endfunction

  // Drive one op into the 32-bit unit and wait for its result.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic sub, output logic [66:0] obs, output int lat);
    @(negedge clock);
    in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    obs = {out_cout, out_ovf, out_zero, 64'(out_sum)};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b sum=%h c=%b o=%b z=%b required all 0",
               out_valid, out_sum, out_cout, out_ovf, out_zero);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    vec_t t[2];
    logic [66:0] obs, exp;
    int lat;
    t[0] = '{32'd111, 32'd222, 1'b0, 1'b0, 32'd333, 1'b0, 1'b0, 1'b0};
    t[1] = '{32'd333, 32'd444, 1'b1, 1'b0, 32'd778, 1'b0, 1'b0, 1'b0};
    foreach (t[i]) begin
      drive_op(t[i].a, t[i].b, t[i].c, t[i].sub, obs, lat);
      exp = {t[i].co, t[i].ov, t[i].z, 64'(t[i].s)};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL add[%0d]: got %h required %h", i, obs, exp);
      end
      n_vec++;
      if (lat !== 7) begin
        n_err++;
        $display("FAIL add_latency[%0d]: got %0d required 7", i, lat);
      end
    end
  endtask

  task automatic test_sub();
    vec_t t[3];
    logic [66:0] obs, exp;
    int lat;
    t[0] = '{32'd15, 32'd71, 1'b0, 1'b1, 32'hFFFF_FFC8, 1'b0, 1'b0, 1'b0};
    t[1] = '{32'd22, 32'd22, 1'b0, 1'b1, 32'd0,         1'b1, 1'b0, 1'b1};
    t[2] = '{32'd10, 32'd3,  1'b1, 1'b1, 32'd7,         1'b1, 1'b0, 1'b0};
    foreach (t[i]) begin
      drive_op(t[i].a, t[i].b, t[i].c, t[i].sub, obs, lat);
      exp = {t[i].co, t[i].ov, t[i].z, 64'(t[i].s)};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL sub[%0d]: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t t[4];
    logic [66:0] obs, exp;
    int lat;
    t[0] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    t[1] = '{32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1};
    t[2] = '{32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    t[3] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1};
    foreach (t[i]) begin
      drive_op(t[i].a, t[i].b, t[i].c, t[i].sub, obs, lat);
      exp = {t[i].co, t[i].ov, t[i].z, 64'(t[i].s)};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL ovf_wrap[%0d]: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [66:0] q[$];
    logic [66:0] obs, exp, snap;
    logic        stalled, acc, dup;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; acc = 1'b0; snap = '0;
    @(negedge clock);
    in_valid = 1'b0;
    while (got < 20 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (stalled) begin
        obs = {out_cout, out_ovf, out_zero, 64'(out_sum)};
        n_vec++;
        if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, snap}) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b rdy=%b %h required v=1 rdy=0 %h",
                   out_valid, in_ready, obs, snap);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent >= 20) begin
        in_valid = 1'b0;
      end else if (acc || !in_valid) begin
        in_a     = $urandom;
        in_b     = $urandom;
        in_c     = 1'($urandom_range(0, 1));
        in_sub   = 1'($urandom_range(0, 1));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      #1;
      acc = in_valid & in_ready;
      if (acc) begin
        q.push_back(model(32, {32'd0, in_a}, {32'd0, in_b}, in_c, in_sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        obs = {out_cout, out_ovf, out_zero, 64'(out_sum)};
        exp = (q.size() > 0) ? q.pop_front() : '1;
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL stream[%0d]: got %h required %h", got, obs, exp);
        end
        got++;
      end
      stalled = out_valid & ~out_ready;
      snap    = {out_cout, out_ovf, out_zero, 64'(out_sum)};
    end
    n_vec++;
    if (got !== 20) begin
      n_err++;
      $display("FAIL stream_count: got %0d results required 20", got);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    dup = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) dup = 1'b1;
    end
    n_vec++;
    if (dup !== 1'b0) begin
      n_err++;
      $display("FAIL stream_extra: got extra out_valid=%b required 0", dup);
    end
  endtask

  task automatic test_width_sweep();
    int          widths[3] = '{4, 16, 64};
    int          explat[3] = '{4, 6, 8};
    int          lat[3];
    logic [66:0] obs[3];
    logic [66:0] exp;
    logic [2:0]  seen;
    int          n;
    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
      if (v == 0) begin
        sw_a = 64'hFFFF_FFFF_FFFF_FFFF; sw_b = 64'd0; sw_c = 1'b1; sw_sub = 1'b0;
      end else begin
        sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
        sw_c = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
      end
      sw_valid = 1'b1;
      @(posedge clock);
      #1 sw_valid = 1'b0;
      n = 1;
      seen = 3'b000;
      for (int w = 0; w < 3; w++) begin
        lat[w] = 0;
        obs[w] = '0;
      end
      while (seen != 3'b111 && n < 30) begin
        @(negedge clock);
        if (w4_valid && !seen[0]) begin
          seen[0] = 1'b1; lat[0] = n; obs[0] = {w4_cout, w4_ovf, w4_zero, 64'(w4_sum)};
        end
        if (w16_valid && !seen[1]) begin
          seen[1] = 1'b1; lat[1] = n; obs[1] = {w16_cout, w16_ovf, w16_zero, 64'(w16_sum)};
        end
        if (w64_valid && !seen[2]) begin
          seen[2] = 1'b1; lat[2] = n; obs[2] = {w64_cout, w64_ovf, w64_zero, w64_sum};
        end
        if (seen != 3'b111) begin
          @(posedge clock);
          n++;
        end
      end
      for (int w = 0; w < 3; w++) begin
        exp = model(widths[w], sw_a, sw_b, sw_c, sw_sub);
        n_vec++;
        if (obs[w] !== exp) begin
          n_err++;
          $display("FAIL sweep_w%0d[%0d]: got %h required %h", widths[w], v, obs[w], exp);
        end
        n_vec++;
        if (lat[w] !== explat[w]) begin
          n_err++;
          $display("FAIL sweep_lat_w%0d[%0d]: got %0d required %0d", widths[w], v, lat[w], explat[w]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    int   cnt;
    logic stale;
    @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'(i + 5); in_b = 32'd1; in_c = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    n_vec++;
    if ({out_valid, out_sum} !== {1'b1, 32'd6}) begin
      n_err++;
      $display("FAIL midreset_held: got v=%b sum=%h required v=1 sum=00000006", out_valid, out_sum);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 36'd0) begin
      n_err++;
      $display("FAIL midreset_clear: got v=%b sum=%h c=%b o=%b z=%b required all 0",
               out_valid, out_sum, out_cout, out_ovf, out_zero);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) stale = 1'b1;
    end
    n_vec++;
    if ({stale, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_stale: got stale=%b in_ready=%b required stale=0 in_ready=1", stale, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_width_sweep();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
